// File: rtl/risc16b_mem_ctrl.sv
// risc16b memory/MMIO controller: byte-addressed big-endian halfword store behind two
// independent wait-stated req/ready ports, plus an LED register and snapshot cycle counter.

module risc16b_mem_port #(
  parameter int AW   = 16,
  parameter int WAIT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    we_i,
  input  logic [15:0]   wdata_i,
  output logic          done_o,
  output logic [AW-1:0] addr_o,
  output logic [1:0]    we_o,
  output logic [15:0]   wdata_o,
  output logic          ready_o
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    we_q, we_d;
  logic [15:0]   wdata_q, wdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // cnt_q counts the edges still to pass before completion; with WAIT=0 the
  // acceptance edge is itself the completion edge, so back-to-back gives one per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    done_o  = 1'b0;
    if (req_i && (state_q == IDLE || ready_q)) begin
      state_d = BUSY;
      addr_d  = addr_i;
      we_d    = we_i;
      wdata_d = wdata_i;
      if (WAIT == 0) begin
        done_o  = 1'b1;
        ready_d = 1'b1;
      end else begin
        cnt_d = 4'(WAIT - 1);
      end
    end else if (state_q == BUSY) begin
      if (ready_q) begin
        state_d = IDLE;
      end else if (cnt_q == '0) begin
        done_o  = 1'b1;
        ready_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  assign addr_o  = (WAIT == 0) ? addr_i  : addr_q;
  assign we_o    = (WAIT == 0) ? we_i    : we_q;
  assign wdata_o = (WAIT == 0) ? wdata_i : wdata_q;
  assign ready_o = ready_q;
endmodule

module risc16b_mem_ctrl #(
  parameter int          ADDR_W    = 16,
  parameter int          MEM_BYTES = 65536,
  parameter int          I_WAIT    = 0,
  parameter int          D_WAIT    = 0,
  parameter logic [7:0]  MMIO_PAGE = 8'h7f,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [15:0]       i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic [1:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [15:0]       d_wdata,
  output logic [15:0]       d_rdata,
  output logic              d_ready,
  output logic [15:0]       led
);
  localparam int MA_W  = $clog2(MEM_BYTES);
  localparam int OFF_W = ADDR_W - 9;
  localparam logic [OFF_W-1:0] OFF_LED = OFF_W'(0);
  localparam logic [OFF_W-1:0] OFF_CLO = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_CHI = OFF_W'(2);

  logic              i_done, d_done;
  logic [ADDR_W-1:0] i_a, d_a;
  logic [1:0]        d_we_c, i_we_unused;
  logic [15:0]       d_wd_c, i_wd_unused;
  logic [15:0]       i_rdata_q, d_rdata_q, led_q, snap_q;
  logic [31:0]       cyc_q;
  logic [7:0]        mem_q [MEM_BYTES];
  logic [MA_W-1:0]   i_hi, i_lo, d_hi, d_lo;
  logic              i_mmio, d_mmio;
  logic [OFF_W-1:0]  d_off;
  logic [15:0]       d_rword;
  logic              addr_unused;

  risc16b_mem_port #(.AW(ADDR_W), .WAIT(I_WAIT)) u_iport (
    .clk(clk), .rst(rst), .req_i(i_req), .addr_i(i_addr), .we_i(2'b00), .wdata_i(16'h0000),
    .done_o(i_done), .addr_o(i_a), .we_o(i_we_unused), .wdata_o(i_wd_unused), .ready_o(i_ready)
  );

  risc16b_mem_port #(.AW(ADDR_W), .WAIT(D_WAIT)) u_dport (
    .clk(clk), .rst(rst), .req_i(d_req), .addr_i(d_addr), .we_i(d_we), .wdata_i(d_wdata),
    .done_o(d_done), .addr_o(d_a), .we_o(d_we_c), .wdata_o(d_wd_c), .ready_o(d_ready)
  );

  // Address bit 0 only selects a byte lane; word accesses always cover both bytes.
  assign addr_unused = i_a[0] ^ d_a[0];
  assign i_hi   = {i_a[MA_W-1:1], 1'b0};
  assign i_lo   = {i_a[MA_W-1:1], 1'b1};
  assign d_hi   = {d_a[MA_W-1:1], 1'b0};
  assign d_lo   = {d_a[MA_W-1:1], 1'b1};
  assign i_mmio = (i_a[ADDR_W-1 -: 8] == MMIO_PAGE);
  assign d_mmio = (d_a[ADDR_W-1 -: 8] == MMIO_PAGE);
  assign d_off  = d_a[ADDR_W-9:1];

  always_comb begin
    d_rword = {mem_q[d_hi], mem_q[d_lo]};
    if (d_mmio) begin
      if (d_off == OFF_LED)      d_rword = led_q;
      else if (d_off == OFF_CLO) d_rword = cyc_q[15:0];
      else if (d_off == OFF_CHI) d_rword = snap_q;
      else                       d_rword = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      led_q     <= '0;
      snap_q    <= '0;
      cyc_q     <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (i_done) i_rdata_q <= i_mmio ? 16'h0000 : {mem_q[i_hi], mem_q[i_lo]};
      if (d_done) begin
        d_rdata_q <= d_rword;
        if (d_mmio && d_off == OFF_CLO && d_we_c == 2'b00) snap_q <= cyc_q[31:16];
        if (d_mmio && d_off == OFF_LED) begin
          if (d_we_c[0]) led_q[15:8] <= d_wd_c[15:8];
          if (d_we_c[1]) led_q[7:0]  <= d_wd_c[7:0];
        end
      end
    end
  end

  // Reads above sample the pre-edge array, so a same-edge I read sees the old bytes.
  always_ff @(posedge clk) begin
    if (!rst && d_done && !d_mmio) begin
      if (d_we_c[0]) mem_q[d_hi] <= d_wd_c[15:8];
      if (d_we_c[1]) mem_q[d_lo] <= d_wd_c[7:0];
    end
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign led     = led_q;
endmodule
